// File: rtl/jailbreak_bridge_master.sv
// Bridge initiator: queues valid/ready commands and issues single-word bridge
// reads/writes, returning read data on a valid/ready response stream.
module jailbreak_bridge_master #(
    parameter int DEPTH        = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] bridge_addr,
    output logic        bridge_wr,
    output logic [31:0] bridge_wr_data,
    output logic        bridge_rd,
    input  logic [31:0] bridge_rd_data,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_READ_WAIT = 2'd1;
    localparam logic [1:0] S_RESP      = 2'd2;

    logic          r_q_wr   [DEPTH];
    logic [31:0]   r_q_addr [DEPTH];
    logic [31:0]   r_q_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [3:0]    r_lat_cnt;

    logic w_push;
    logic w_pop;

    assign cmd_ready = (r_count != CW'(DEPTH));
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign busy      = (r_count != '0) || (r_state != S_IDLE);

    // Queue storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wr[r_wptr]   <= cmd_wr;
            r_q_addr[r_wptr] <= cmd_addr;
            r_q_data[r_wptr] <= cmd_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_lat_cnt      <= '0;
            bridge_wr      <= 1'b0;
            bridge_rd      <= 1'b0;
            bridge_addr    <= '0;
            bridge_wr_data <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
        end else begin
            bridge_wr <= 1'b0;
            bridge_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        bridge_addr <= r_q_addr[r_rptr];
                        if (r_q_wr[r_rptr]) begin
                            bridge_wr      <= 1'b1;
                            bridge_wr_data <= r_q_data[r_rptr];
                        end else begin
                            bridge_rd <= 1'b1;
                            r_lat_cnt <= 4'(READ_LATENCY);
                            r_state   <= S_READ_WAIT;
                        end
                    end
                end
                // Counter hits 1 exactly READ_LATENCY edges after the strobe edge.
                S_READ_WAIT: begin
                    if (r_lat_cnt == 4'd1) begin
                        rsp_data  <= bridge_rd_data;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jailbreak_bridge_master.sv
// Directed bench for jailbreak_bridge_master: vector table plus hand-written
// sequences for queue-full, read-then-write ordering and reset mid-read.
module tb_jailbreak_bridge_master;
    localparam int DEPTH = 4;
    localparam int RL    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wr_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data = '0;
    logic        busy;

    jailbreak_bridge_master #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd),
        .bridge_rd_data(bridge_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Target model: registers addr-derived data every cycle.
    always @(posedge clk) bridge_rd_data <= 32'hA5A5_0001 + bridge_addr;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    ev_t  stb_q[$];
    rsp_t rsp_q[$];
    int   vld_cnt = 0;
    int   ovl_cnt = 0;

    always @(negedge clk) begin
        #2;
        if (bridge_wr || bridge_rd) begin
            ev_t e;
            if (bridge_wr && bridge_rd) ovl_cnt++;
            e.wr = bridge_wr; e.addr = bridge_addr; e.data = bridge_wr_data; e.cyc = cyc;
            stb_q.push_back(e);
        end
        if (rsp_valid) vld_cnt++;
        if (rsp_valid && rsp_ready) begin
            rsp_t r;
            r.data = rsp_data; r.cyc = cyc;
            rsp_q.push_back(r);
        end
    end

    int checks = 0;
    int errors = 0;
    int acc_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Holds cmd_valid high on return so consecutive calls stream back to back.
    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wr_data = data;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                @(negedge clk);
                acc_cyc = cyc;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail("push_accept");
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        stb_q.delete();
        rsp_q.delete();
        vld_cnt = 0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit flag;
        int n0, v0, a0;
        logic [31:0] exp_d;

        vecs[0] = '{wr: 1'b0, addr: 32'h0000_0000, wdata: 32'h0,         exp_rsp: 32'hA5A5_0001};
        vecs[1] = '{wr: 1'b1, addr: 32'h0000_0004, wdata: 32'hDEAD_BEEF, exp_rsp: 32'h0};
        vecs[2] = '{wr: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,         exp_rsp: 32'hA5A5_0011};
        vecs[3] = '{wr: 1'b0, addr: 32'hFFFF_FFF0, wdata: 32'h0,         exp_rsp: 32'hA5A4_FFF1};
        vecs[4] = '{wr: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'h0000_0000, exp_rsp: 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_bridge_wr", 32'(bridge_wr), 32'd0);
        chk("rst_bridge_rd", 32'(bridge_rd), 32'd0);
        chk("rst_bridge_addr", bridge_addr, 32'd0);
        chk("rst_bridge_wr_data", bridge_wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        flag = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cmd_ready || busy || bridge_wr || bridge_rd || rsp_valid) flag = 0;
        end
        chk("idle_20_cycles", 32'(flag), 32'd1);

        // Three back-to-back writes
        clear_logs();
        push(1'b1, 32'h0, 32'h11);
        a0 = acc_cyc;
        push(1'b1, 32'h0, 32'h22);
        push(1'b1, 32'h0, 32'h33);
        idle(6);
        chk("b2b_count", 32'(stb_q.size()), 32'd3);
        if (stb_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                exp_d = 32'h11 * (k + 1);
                chk("b2b_is_wr", 32'(stb_q[k].wr), 32'd1);
                chk("b2b_data", stb_q[k].data, exp_d);
                chk("b2b_cycle", 32'(stb_q[k].cyc), 32'(a0 + 1 + k));
            end
        end
        chk("b2b_no_rsp", 32'(vld_cnt), 32'd0);

        // Table-driven single commands, rsp_ready held high
        rsp_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            push(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            a0 = acc_cyc;
            idle(10);
            chk("vec_strobe_count", 32'(stb_q.size()), 32'd1);
            if (stb_q.size() == 1) begin
                chk("vec_strobe_type", 32'(stb_q[0].wr), 32'(vecs[v].wr));
                chk("vec_addr", stb_q[0].addr, vecs[v].addr);
                chk("vec_issue_cycle", 32'(stb_q[0].cyc), 32'(a0 + 1));
                if (vecs[v].wr) begin
                    chk("vec_wr_data", stb_q[0].data, vecs[v].wdata);
                    chk("vec_wr_no_rsp", 32'(vld_cnt), 32'd0);
                end else begin
                    chk("vec_rsp_pulse", 32'(vld_cnt), 32'd1);
                    chk("vec_rsp_count", 32'(rsp_q.size()), 32'd1);
                    if (rsp_q.size() == 1) begin
                        chk("vec_rsp_data", rsp_q[0].data, vecs[v].exp_rsp);
                        chk("vec_rsp_latency", 32'(rsp_q[0].cyc - stb_q[0].cyc), 32'(RL));
                    end
                end
            end
            chk("vec_busy_after", 32'(busy), 32'd0);
        end

        // Queue full with response back-pressure
        rsp_ready = 1'b0;
        clear_logs();
        for (int k = 0; k < DEPTH + 1; k++) push(1'b0, 32'h100 + 32'(4 * k), 32'h0);
        chk("full_cmd_ready_low", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h114; cmd_wr_data = '0;
        flag = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_ready || !rsp_valid || rsp_data !== 32'hA5A5_0101) flag = 0;
        end
        chk("full_hold_and_stable", 32'(flag), 32'd1);
        chk("full_single_issue", 32'(stb_q.size()), 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        idle(40);
        chk("full_rsp_count", 32'(rsp_q.size()), 32'd5);
        chk("full_stb_count", 32'(stb_q.size()), 32'd5);
        if (rsp_q.size() == 5 && stb_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("full_rsp_order", rsp_q[k].data, 32'hA5A5_0101 + 32'(4 * k));
                chk("full_stb_addr", stb_q[k].addr, 32'h100 + 32'(4 * k));
            end
            chk("full_first_reissue", 32'(stb_q[1].cyc - rsp_q[0].cyc), 32'd2);
            for (int k = 2; k < 5; k++)
                chk("full_read_spacing", 32'(stb_q[k].cyc - stb_q[k-1].cyc), 32'(RL + 2));
        end

        // Read followed by write: write waits for the response handshake
        rsp_ready = 1'b0;
        clear_logs();
        push(1'b0, 32'h20, 32'h0);
        push(1'b1, 32'h24, 32'h55);
        idle(10);
        chk("rw_write_held", 32'(stb_q.size()), 32'd1);
        rsp_ready = 1'b1;
        idle(6);
        chk("rw_strobes", 32'(stb_q.size()), 32'd2);
        chk("rw_rsp_count", 32'(rsp_q.size()), 32'd1);
        if (stb_q.size() == 2 && rsp_q.size() == 1) begin
            chk("rw_first_is_rd", 32'(stb_q[0].wr), 32'd0);
            chk("rw_second_is_wr", 32'(stb_q[1].wr), 32'd1);
            chk("rw_wr_data", stb_q[1].data, 32'h55);
            chk("rw_rsp_data", rsp_q[0].data, 32'hA5A5_0021);
            chk("rw_wr_after_hs", 32'(stb_q[1].cyc - rsp_q[0].cyc), 32'd2);
        end

        // Reset asserted while the read is in flight
        clear_logs();
        push(1'b0, 32'h30, 32'h0);
        push(1'b1, 32'h34, 32'h77);
        cmd_valid = 1'b0;
        chk("mid_rd_strobe_seen", 32'(bridge_rd), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_bridge_rd", 32'(bridge_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_bridge_addr", bridge_addr, 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n0 = stb_q.size();
        v0 = vld_cnt;
        idle(12);
        chk("post_rst_no_strobe", 32'(stb_q.size()), 32'(n0));
        chk("post_rst_no_rsp", 32'(vld_cnt), 32'(v0));
        chk("post_rst_busy", 32'(busy), 32'd0);

        chk("no_strobe_overlap", 32'(ovl_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
